// File: rtl/pe_lane_pkg.sv
// Shared configuration for pe_lane: default datapath sizes (PECfg) and the
// control-side state/config types (PECtlCfg).
package PECfg;
    localparam int DEF_ROWS    = 4;
    localparam int DEF_DWD     = 8;
    localparam int DEF_PSUMDWD = 24;
    localparam int DEF_WDEPTH  = 8;
endpackage

package PECtlCfg;
    // Latched K is held at a fixed width wide enough for any WDEPTH up to 255.
    localparam int K_MAXW = 8;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        ACC,
        CHAIN,
        OUT
    } pe_state_t;

    typedef struct packed {
        logic [K_MAXW-1:0] k;
        logic              chain;
    } lane_cfg_t;
endpackage

// File: rtl/pe_lane_mac.sv
// One psum row: signed multiply-accumulate, or psum add on the chain beat.
// Saturating accumulation is enabled by defining PE_LANE_SAT_EN; otherwise sums wrap.
module pe_lane_mac #(
    parameter int DWD     = 8,
    parameter int PSUMDWD = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      mac_en,
    input  logic                      add_en,
    input  logic signed [DWD-1:0]     in_a,
    input  logic signed [DWD-1:0]     in_w,
    input  logic signed [PSUMDWD-1:0] psum_in,
    output logic signed [PSUMDWD-1:0] acc
);
    localparam logic signed [PSUMDWD-1:0] PSUM_MAX = {1'b0, {(PSUMDWD-1){1'b1}}};
    localparam logic signed [PSUMDWD-1:0] PSUM_MIN = {1'b1, {(PSUMDWD-1){1'b0}}};

    logic signed [2*DWD-1:0]   prod;
    logic signed [PSUMDWD:0]   addend;
    logic signed [PSUMDWD:0]   sum;
    logic signed [PSUMDWD-1:0] acc_next;

    assign prod = in_a * in_w;

    // One guard bit exposes overflow so the saturating build can clamp.
    always_comb begin
        addend = add_en ? {psum_in[PSUMDWD-1], psum_in} : (PSUMDWD+1)'(prod);
        sum    = {acc[PSUMDWD-1], acc} + addend;
`ifdef PE_LANE_SAT_EN
        if (sum[PSUMDWD] != sum[PSUMDWD-1])
            acc_next = sum[PSUMDWD] ? PSUM_MIN : PSUM_MAX;
        else
            acc_next = sum[PSUMDWD-1:0];
`else
        acc_next = sum[PSUMDWD-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (mac_en || add_en)
            acc <= acc_next;
    end
endmodule

// File: rtl/pe_lane.sv
// Processing-element lane: loads K weight columns, accumulates K broadcast inputs
// across ROWS psums, optionally adds an upstream psum, then presents the result.
// Optional build macro: PE_LANE_SAT_EN (saturating accumulation).
module pe_lane
    import PECtlCfg::*;
#(
    parameter int ROWS    = PECfg::DEF_ROWS,
    parameter int DWD     = PECfg::DEF_DWD,
    parameter int PSUMDWD = PECfg::DEF_PSUMDWD,
    parameter int WDEPTH  = PECfg::DEF_WDEPTH,
    localparam int KW     = $clog2(WDEPTH + 1)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [KW-1:0]                     i_K,
    input  logic                              i_chain,
    input  logic                              Weight_rdy,
    output logic                              Weight_ack,
    input  logic [ROWS-1:0][DWD-1:0]          i_Weight,
    input  logic                              Input_rdy,
    output logic                              Input_ack,
    input  logic [DWD-1:0]                    i_Input,
    input  logic                              LPE_rdy,
    output logic                              LPE_ack,
    input  logic [ROWS-1:0][PSUMDWD-1:0]      i_Psum_LPE,
    output logic                              POUT_rdy,
    input  logic                              POUT_ack,
    output logic [ROWS-1:0][PSUMDWD-1:0]      o_Psum,
    output logic                              o_busy,
    output logic                              o_err
);
    localparam int AW = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;

    pe_state_t         state_reg;
    lane_cfg_t         cfg_reg;
    logic [K_MAXW-1:0] col_reg;

    logic k_valid;
    logic last_col;
    logic w_beat;
    logic in_beat;
    logic lpe_beat;
    logic acc_clr;

    assign k_valid  = (i_K != '0) && (i_K <= KW'(WDEPTH));
    assign last_col = (col_reg == cfg_reg.k - K_MAXW'(1));
    assign w_beat   = (state_reg == WLOAD) && Weight_rdy && Weight_ack;
    assign in_beat  = (state_reg == ACC)   && Input_rdy  && Input_ack;
    assign lpe_beat = (state_reg == CHAIN) && LPE_rdy    && LPE_ack;
    assign acc_clr  = (state_reg == IDLE)  && i_start    && k_valid;

    // Ack/rdy/busy are registered and updated on the same edges as the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            cfg_reg    <= '0;
            col_reg    <= '0;
            Weight_ack <= 1'b0;
            Input_ack  <= 1'b0;
            LPE_ack    <= 1'b0;
            POUT_rdy   <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        if (k_valid) begin
                            cfg_reg    <= '{k: K_MAXW'(i_K), chain: i_chain};
                            col_reg    <= '0;
                            state_reg  <= WLOAD;
                            Weight_ack <= 1'b1;
                            o_busy     <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                WLOAD: begin
                    if (w_beat) begin
                        if (last_col) begin
                            col_reg    <= '0;
                            state_reg  <= ACC;
                            Weight_ack <= 1'b0;
                            Input_ack  <= 1'b1;
                        end else begin
                            col_reg <= col_reg + K_MAXW'(1);
                        end
                    end
                end
                ACC: begin
                    if (in_beat) begin
                        if (last_col) begin
                            col_reg   <= '0;
                            Input_ack <= 1'b0;
                            if (cfg_reg.chain) begin
                                state_reg <= CHAIN;
                                LPE_ack   <= 1'b1;
                            end else begin
                                state_reg <= OUT;
                                POUT_rdy  <= 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + K_MAXW'(1);
                        end
                    end
                end
                CHAIN: begin
                    if (lpe_beat) begin
                        LPE_ack   <= 1'b0;
                        POUT_rdy  <= 1'b1;
                        state_reg <= OUT;
                    end
                end
                OUT: begin
                    if (POUT_ack) begin
                        POUT_rdy  <= 1'b0;
                        o_busy    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic signed [DWD-1:0]     wmem [WDEPTH];
            logic signed [DWD-1:0]     w_rd;
            logic signed [PSUMDWD-1:0] acc;

            // Weight store is not reset; it is always rewritten before use.
            always_ff @(posedge i_clk) begin
                if (w_beat)
                    wmem[col_reg[AW-1:0]] <= i_Weight[gi];
            end

            assign w_rd = wmem[col_reg[AW-1:0]];

            pe_lane_mac #(
                .DWD     (DWD),
                .PSUMDWD (PSUMDWD)
            ) u_mac (
                .clk     (i_clk),
                .rst     (i_rst),
                .clr     (acc_clr),
                .mac_en  (in_beat),
                .add_en  (lpe_beat),
                .in_a    (i_Input),
                .in_w    (w_rd),
                .psum_in (i_Psum_LPE[gi]),
                .acc     (acc)
            );

            assign o_Psum[gi] = acc;
        end
    endgenerate
endmodule

// File: tb/tb_pe_lane.sv
// Directed bench for pe_lane: a default-width lane plus a 16-bit-psum lane driven
// in parallel so overflow behaviour can be checked on the narrow one.
module tb_pe_lane;
    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_start;
    logic [3:0]          i_K;
    logic                i_chain;
    logic                Weight_rdy, Input_rdy, LPE_rdy, POUT_ack;
    logic [3:0][7:0]     i_Weight;
    logic [7:0]          i_Input;
    logic [3:0][23:0]    lpe24;
    logic [3:0][15:0]    lpe16;
    logic [3:0][23:0]    psum24;
    logic [3:0][15:0]    psum16;
    logic                w_ack, in_ack, lpe_ack, pout_rdy, busy, err;
    logic                w_ack16, in_ack16, lpe_ack16, pout_rdy16, busy16, err16;

    int cmp_count  = 0;
    int fail_count = 0;

    always #5 i_clk = ~i_clk;

    always_comb begin
        for (int r = 0; r < 4; r++) lpe16[r] = lpe24[r][15:0];
    end

    pe_lane dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_K(i_K), .i_chain(i_chain),
        .Weight_rdy(Weight_rdy), .Weight_ack(w_ack), .i_Weight(i_Weight),
        .Input_rdy(Input_rdy), .Input_ack(in_ack), .i_Input(i_Input),
        .LPE_rdy(LPE_rdy), .LPE_ack(lpe_ack), .i_Psum_LPE(lpe24),
        .POUT_rdy(pout_rdy), .POUT_ack(POUT_ack), .o_Psum(psum24),
        .o_busy(busy), .o_err(err)
    );

    pe_lane #(.PSUMDWD(16)) dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_K(i_K), .i_chain(i_chain),
        .Weight_rdy(Weight_rdy), .Weight_ack(w_ack16), .i_Weight(i_Weight),
        .Input_rdy(Input_rdy), .Input_ack(in_ack16), .i_Input(i_Input),
        .LPE_rdy(LPE_rdy), .LPE_ack(lpe_ack16), .i_Psum_LPE(lpe16),
        .POUT_rdy(pout_rdy16), .POUT_ack(POUT_ack), .o_Psum(psum16),
        .o_busy(busy16), .o_err(err16)
    );

    // All stimulus changes and samples happen on the falling edge.
    task automatic start_job(input int k, input logic chain);
        i_start = 1'b1; i_K = 4'(k); i_chain = chain;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic push_w(input int a, input int b, input int c, input int d);
        int n = 0;
        i_Weight[0] = 8'(a); i_Weight[1] = 8'(b); i_Weight[2] = 8'(c); i_Weight[3] = 8'(d);
        Weight_rdy = 1'b1;
        while (w_ack !== 1'b1 && n < 40) begin @(negedge i_clk); n++; end
        if (n >= 40) begin
            cmp_count++; fail_count++;
            $display("FAIL weight_ack_timeout got %b want 1", w_ack);
        end
        @(negedge i_clk);
        Weight_rdy = 1'b0;
    endtask

    task automatic push_in(input int v);
        int n = 0;
        i_Input = 8'(v);
        Input_rdy = 1'b1;
        while (in_ack !== 1'b1 && n < 40) begin @(negedge i_clk); n++; end
        if (n >= 40) begin
            cmp_count++; fail_count++;
            $display("FAIL input_ack_timeout got %b want 1", in_ack);
        end
        @(negedge i_clk);
        Input_rdy = 1'b0;
    endtask

    task automatic push_lpe(input int a, input int b, input int c, input int d);
        int n = 0;
        lpe24[0] = 24'(a); lpe24[1] = 24'(b); lpe24[2] = 24'(c); lpe24[3] = 24'(d);
        LPE_rdy = 1'b1;
        while (lpe_ack !== 1'b1 && n < 40) begin @(negedge i_clk); n++; end
        if (n >= 40) begin
            cmp_count++; fail_count++;
            $display("FAIL lpe_ack_timeout got %b want 1", lpe_ack);
        end
        @(negedge i_clk);
        LPE_rdy = 1'b0;
    endtask

    task automatic pop_out();
        POUT_ack = 1'b1;
        @(negedge i_clk);
        POUT_ack = 1'b0;
    endtask

    task automatic test_reset();
        cmp_count++;
        if ({w_ack, in_ack, lpe_ack, pout_rdy, busy, err} !== 6'b0) begin
            fail_count++;
            $display("FAIL reset_ctrl got %b want 000000", {w_ack, in_ack, lpe_ack, pout_rdy, busy, err});
        end
        cmp_count++;
        if (psum24 !== '0) begin
            fail_count++;
            $display("FAIL reset_psum got %h want 0", psum24);
        end
        $display("reset: ctrl=%b psum=%h", {w_ack, in_ack, lpe_ack, pout_rdy, busy, err}, psum24);
    endtask

    // K=2, no chain; also covers the held-off output (POUT_ack low 10 cycles).
    task automatic test_basic(input string tag);
        int exp [4] = '{19, 8, 7, 18};
        logic [3:0][23:0] snap;
        start_job(2, 1'b0);
        cmp_count++;
        if (busy !== 1'b1 || w_ack !== 1'b1) begin
            fail_count++;
            $display("FAIL %s_wload got busy=%b wack=%b want 1 1", tag, busy, w_ack);
        end
        push_w(1, 3, 0, -2);
        push_w(2, -1, 1, 4);
        push_in(5);
        cmp_count++;
        if (pout_rdy !== 1'b0) begin
            fail_count++;
            $display("FAIL %s_early_pout got %b want 0", tag, pout_rdy);
        end
        push_in(7);
        cmp_count++;
        if (pout_rdy !== 1'b1) begin
            fail_count++;
            $display("FAIL %s_pout_latency got %b want 1", tag, pout_rdy);
        end
        for (int r = 0; r < 4; r++) begin
            cmp_count++;
            if ($signed(psum24[r]) !== exp[r]) begin
                fail_count++;
                $display("FAIL %s_row%0d got %0d want %0d", tag, r, $signed(psum24[r]), exp[r]);
            end
        end
        snap = psum24;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            cmp_count++;
            if (psum24 !== snap || pout_rdy !== 1'b1 || in_ack !== 1'b0) begin
                fail_count++;
                $display("FAIL %s_hold%0d got psum=%h rdy=%b iack=%b want psum=%h rdy=1 iack=0",
                         tag, i, psum24, pout_rdy, in_ack, snap);
            end
        end
        pop_out();
        cmp_count++;
        if (busy !== 1'b0 || pout_rdy !== 1'b0) begin
            fail_count++;
            $display("FAIL %s_done got busy=%b rdy=%b want 0 0", tag, busy, pout_rdy);
        end
        $display("%s: psum=%0d,%0d,%0d,%0d", tag, $signed(snap[0]), $signed(snap[1]),
                 $signed(snap[2]), $signed(snap[3]));
    endtask

    task automatic test_chain();
        int exp [4] = '{106, 13, 17, -30};
        start_job(1, 1'b1);
        push_w(2, 1, -1, 0);
        push_in(3);
        cmp_count++;
        if (pout_rdy !== 1'b0 || lpe_ack !== 1'b1) begin
            fail_count++;
            $display("FAIL chain_wait got rdy=%b lack=%b want 0 1", pout_rdy, lpe_ack);
        end
        repeat (3) @(negedge i_clk);
        cmp_count++;
        if (pout_rdy !== 1'b0) begin
            fail_count++;
            $display("FAIL chain_no_lpe got %b want 0", pout_rdy);
        end
        push_lpe(100, 10, 20, -30);
        cmp_count++;
        if (pout_rdy !== 1'b1 || lpe_ack !== 1'b0) begin
            fail_count++;
            $display("FAIL chain_pout got rdy=%b lack=%b want 1 0", pout_rdy, lpe_ack);
        end
        for (int r = 0; r < 4; r++) begin
            cmp_count++;
            if ($signed(psum24[r]) !== exp[r]) begin
                fail_count++;
                $display("FAIL chain_row%0d got %0d want %0d", r, $signed(psum24[r]), exp[r]);
            end
        end
        $display("chain: psum0=%0d", $signed(psum24[0]));
        pop_out();
    endtask

    task automatic test_bad_k();
        int ks [2] = '{0, 9};
        foreach (ks[i]) begin
            start_job(ks[i], 1'b0);
            cmp_count++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                fail_count++;
                $display("FAIL badk%0d_err got err=%b busy=%b want 1 0", ks[i], err, busy);
            end
            @(negedge i_clk);
            cmp_count++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                fail_count++;
                $display("FAIL badk%0d_pulse got err=%b busy=%b want 0 0", ks[i], err, busy);
            end
            $display("bad K=%0d: err pulse checked", ks[i]);
        end
    endtask

    // 127*127 three times: 48387 fits 24 bits; on 16 bits it wraps or clamps.
    task automatic test_overflow();
        int exp16;
`ifdef PE_LANE_SAT_EN
        exp16 = 32767;
`else
        exp16 = -17149;
`endif
        start_job(3, 1'b0);
        i_start = 1'b1; i_K = 4'd0;
        push_w(127, 127, 127, 127);
        i_start = 1'b0;
        cmp_count++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fail_count++;
            $display("FAIL start_ignored got err=%b busy=%b want 0 1", err, busy);
        end
        push_w(127, 127, 127, 127);
        push_w(127, 127, 127, 127);
        for (int i = 0; i < 3; i++) push_in(127);
        cmp_count++;
        if ($signed(psum24[0]) !== 48387) begin
            fail_count++;
            $display("FAIL ovf_wide got %0d want 48387", $signed(psum24[0]));
        end
        for (int r = 0; r < 4; r++) begin
            cmp_count++;
            if ($signed(psum16[r]) !== exp16) begin
                fail_count++;
                $display("FAIL ovf16_row%0d got %0d want %0d", r, $signed(psum16[r]), exp16);
            end
        end
        $display("overflow: wide=%0d narrow=%0d", $signed(psum24[0]), $signed(psum16[0]));
        pop_out();
    endtask

    task automatic test_mid_reset();
        start_job(2, 1'b0);
        push_w(9, 9, 9, 9);
        push_w(9, 9, 9, 9);
        push_in(4);
        i_rst = 1'b1;
        #1;
        cmp_count++;
        if ({w_ack, in_ack, lpe_ack, pout_rdy, busy, err} !== 6'b0 || psum24 !== '0) begin
            fail_count++;
            $display("FAIL midrst got ctrl=%b psum=%h want 000000 0",
                     {w_ack, in_ack, lpe_ack, pout_rdy, busy, err}, psum24);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        $display("mid-job reset applied");
        test_basic("after_rst");
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_K = '0; i_chain = 1'b0;
        Weight_rdy = 1'b0; Input_rdy = 1'b0; LPE_rdy = 1'b0; POUT_ack = 1'b0;
        i_Weight = '0; i_Input = '0; lpe24 = '0;
        repeat (2) @(negedge i_clk);
        test_reset();
        i_rst = 1'b0;
        @(negedge i_clk);
        test_basic("basic");
        test_chain();
        test_bad_k();
        test_overflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule

// File: doc/pe_lane.md
PE_LANE -- requirements
Module: pe_lane

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of parallel psum rows.
REQ-002 SHALL have parameter DWD, default 8, signed input/weight width.
REQ-003 SHALL have parameter PSUMDWD, default 24, signed psum width; PSUMDWD >= 2*DWD.
REQ-004 SHALL have parameter WDEPTH, default 8, weights held per row.
REQ-005 SHALL have port i_clk, input, 1, sole clock.
REQ-006 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports i_start (1) and i_K (clog2(WDEPTH+1)) as inputs: job start pulse and inputs per job.
REQ-008 SHALL have port i_chain, input, 1: add the incoming LPE psum before output.
REQ-009 SHALL have ports Weight_rdy (in), Weight_ack (out), i_Weight (in, ROWS x DWD): one weight column per beat.
REQ-010 SHALL have ports Input_rdy (in), Input_ack (out), i_Input (in, DWD): one broadcast input per beat.
REQ-011 SHALL have ports LPE_rdy (in), LPE_ack (out), i_Psum_LPE (in, ROWS x PSUMDWD).
REQ-012 SHALL have ports POUT_rdy (out), POUT_ack (in), o_Psum (out, ROWS x PSUMDWD).
REQ-013 SHALL have ports o_busy (out, 1) and o_err (out, 1, one-cycle pulse).

Function
REQ-014 A beat SHALL transfer only when rdy and ack are both high on an i_clk edge; each sender holds rdy and data stable until ack.
REQ-015 FSM states SHALL be IDLE, WLOAD, ACC, CHAIN, OUT.
REQ-016 IDLE + i_start: K in 1..WDEPTH -> latch K and i_chain, clear accumulators and column counter, go WLOAD; otherwise pulse o_err, stay IDLE.
REQ-017 i_start outside IDLE SHALL be ignored.
REQ-018 WLOAD: Weight_ack=1; each beat writes column c of every row, c increments; after beat c=K-1 go ACC with c=0.
REQ-019 ACC: Input_ack=1; each beat acc[r] += sext(i_Input*w[r][c]) for all r in the same cycle; after beat c=K-1 go CHAIN if i_chain latched, else OUT.
REQ-020 CHAIN: LPE_ack=1; on the beat acc[r] += i_Psum_LPE[r]; go OUT.
REQ-021 OUT: POUT_rdy=1, o_Psum=acc; on POUT_ack go IDLE.
REQ-022 Latency: POUT_rdy SHALL rise the cycle after the final Input (non-chain) or LPE (chain) beat.
REQ-023 Without saturation, sums SHALL wrap modulo 2^PSUMDWD.
REQ-024 o_busy SHALL be high in every state except IDLE.
REQ-025 Ack outputs SHALL be low in all states other than the one named above.

Reset
REQ-026 i_rst SHALL immediately force IDLE, all ack outputs and POUT_rdy/o_busy/o_err to 0, o_Psum to 0, counters to 0, latched K to 0, including mid-job; weight storage need not be cleared.

Configuration
REQ-027 With PE_LANE_SAT_EN defined, every accumulation (REQ-019/020) SHALL clamp to the signed PSUMDWD max/min; without it, wrap (REQ-023).

Structure
REQ-028 State enum and a lane-config struct {K, chain} SHALL live in PECtlCfg; ROWS/DWD/PSUMDWD defaults come from PECfg.
REQ-029 The per-row multiply-accumulate with optional saturation SHALL be one sub-module, pe_lane_mac, instantiated ROWS times.

Verification
REQ-030 K=2, no chain, weights rows {1,2},{3,-1}..., inputs 5,7 -> row0=19, row1=8, POUT_rdy the cycle after 2nd input beat.
REQ-031 K=1, chain, weight 2, input 3, LPE psum 100 -> o_Psum=106; POUT_rdy stays low until LPE beat.
REQ-032 POUT_ack held low 10 cycles -> o_Psum stable, POUT_rdy high, Input_ack low throughout.
REQ-033 i_start with K=0 and K=WDEPTH+1 -> o_err pulse, o_busy stays 0.
REQ-034 PSUMDWD=16, DWD=8, accumulate 127*127 three times -> 32767 with PE_LANE_SAT_EN, 48387 mod 2^16 (signed -17149) without.
REQ-035 i_rst asserted during ACC -> next cycle IDLE, all acks 0; fresh job afterward produces correct result.
